// File: rtl/app_mult_param.sv
// Sequential approximate/exact W x W unsigned multiplier; Done pulses n+M+2 edges after the start edge.
// Backpressure: start is only sampled in IDLE, so requests arriving while busy are dropped.
module app_mult_param #(
    parameter int W = 16,
    parameter int K = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [2*W-1:0]   result,
    output logic             busy,
    output logic             Done
);

    localparam int CW = $clog2(W + 1);
    localparam logic [W:0]    LIM    = (W + 1)'(1) << K;
    localparam logic [CW-1:0] LAST_A = CW'(K - 1);
    localparam logic [CW-1:0] LAST_E = CW'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_MULT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [W-1:0]     ra_q;
    logic [W-1:0]     rb_q;
    logic             rmode_q;
    logic [CW-1:0]    sa_q;
    logic [CW-1:0]    sb_q;
    logic [CW-1:0]    cnt_q;
    logic [2*W-1:0]   acc_q;
    logic [2*W-1:0]   mcand_q;
    logic [W-1:0]     mplier_q;
    logic [2*W-1:0]   result_q;
    logic             done_q;

    logic             a_big;
    logic             b_big;
    logic [CW:0]      shamt;

    assign a_big = ({1'b0, ra_q} >= LIM);
    assign b_big = ({1'b0, rb_q} >= LIM);
    assign shamt = {1'b0, sa_q} + {1'b0, sb_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            rmode_q  <= 1'b0;
            sa_q     <= '0;
            sb_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        ra_q    <= a;
                        rb_q    <= b;
                        rmode_q <= mode;
                        sa_q    <= '0;
                        sb_q    <= '0;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    // Exact mode skips normalisation; approx shifts each operand until it fits in K bits.
                    if (rmode_q || (!a_big && !b_big)) begin
                        mcand_q  <= {{W{1'b0}}, ra_q};
                        mplier_q <= rb_q;
                        state_q  <= S_MULT;
                    end else begin
                        if (a_big) begin
                            ra_q <= ra_q >> 1;
                            sa_q <= sa_q + 1'b1;
                        end
                        if (b_big) begin
                            rb_q <= rb_q >> 1;
                            sb_q <= sb_q + 1'b1;
                        end
                    end
                end
                S_MULT: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == (rmode_q ? LAST_E : LAST_A)) begin
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    result_q <= acc_q << shamt;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result = result_q;
    assign Done   = done_q;
    assign busy   = (state_q != S_IDLE);

endmodule

// File: doc/app_mult_param.md
Name: app_mult_param

Overview:
- Parametrised, sequential successor to the fixed-width approximate multiplier driven by start/Done.
- Takes two W-bit unsigned operands on ports and returns a 2W-bit product.
- Approximate mode: keeps only the top K bits of each operand from its leading one, multiplies them with a shift-add loop, then shifts back.
- Exact mode: full W x W shift-add multiply.
- Used as the arithmetic core under a controller/memory wrapper, or stand-alone in benches.

Parameters:
W, 16, operand width in bits (W >= 2)
K, 8, retained significant bits per operand in approximate mode (2 <= K <= W)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
mode  input  1  0 = approximate, 1 = exact; captured with operands
a  input  W  operand A, unsigned, captured on accepted start
b  input  W  operand B, unsigned, captured on accepted start
result  output  2W  product; holds last completed value
busy  output  1  high in every state except IDLE
Done  output  1  one-cycle completion pulse; result valid from this cycle

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at an edge, any state, including mid-operation):
  - state <= IDLE; result <= 0; Done <= 0; busy = 0.
  - All internal registers cleared.
  - The in-flight operation is abandoned, with no Done pulse.
- States: IDLE, NORM, MULT, SHIFT, DONE.
- IDLE:
  - At edge E0 with start=1: capture a, b and mode into ra, rb, rmode.
  - Clear sa, sb, the accumulator and the iteration counter; go to NORM.
  - start is level-sampled. If it is still high on return to IDLE, a new operation starts.
- NORM (approximate, rmode=0):
  - Each edge: if ra >= 2^K, shift ra right by 1 and increment sa; same for rb/sb, independently and in parallel.
  - When both are < 2^K at an edge, go to MULT.
  - Lasts n+1 cycles, n = max(sa_final, sb_final) = max(0, msb(a)-K+1, msb(b)-K+1).
  - Zero operands: no shift, stays 0.
- NORM (exact, rmode=1): no shifts, sa = sb = 0, one cycle.
- MULT: M iterations, M = K (approximate) or W (exact).
  - Each edge: if the LSB of the multiplier register is 1, add the multiplicand register to the 2W-bit accumulator.
  - Then shift the multiplicand left 1 and the multiplier right 1, and increment the counter.
  - After M edges, go to SHIFT.
- SHIFT: one edge.
  - result <= accumulator << (sa+sb), truncated to 2W bits; the value always fits.
  - Go to DONE with Done <= 1.
- DONE: one cycle; Done=1, busy=1. The next edge returns to IDLE with Done <= 0.
- Latency: Done is high in the cycle after edge E0 + n + M + 2.
  - Approximate, W=16/K=8: 10..18 edges.
  - Exact: W+2 edges.
- Arithmetic:
  - Approximate result = floor(a/2^sa) * floor(b/2^sb) * 2^(sa+sb), which is always <= the exact product.
  - Exact when both operands < 2^K.
- start while busy: ignored; operands not recaptured.
- result is stable between Done pulses; changes only on the SHIFT edge or on reset.

Test Plan:
- Reset: rst=1 for 1 edge, then idle 5 cycles -> result=0, Done=0, busy=0 throughout.
- Approx typical (W=16, K=8): a=0x1234, b=0x00FF, mode=0, start 1 cycle -> sa=5, sb=0; Done exactly 15 edges after capture, one cycle wide; result=0x120DE0 (exact would be 0x1221CC).
- Exact: same operands, mode=1 -> Done after 18 edges; result=0x1221CC.
- Max operands: a=b=0xFFFF -> mode=0: 0xFE010000 after 18 edges; mode=1: 0xFFFE0001 after 18 edges.
- Zero/small: a=0, b=0xFFFF, mode=0 -> result=0, Done after 18 edges. a=0x00C8, b=0x0003, mode=0 -> result=600 (0x258) after 10 edges.
- Control corners:
  - start held high 3 cycles, then a new a/b pulsed mid-operation -> first operation's result unchanged, busy stays 1.
  - rst asserted during MULT -> no Done, result=0, IDLE next cycle.
  - Subsequent start -> correct result.
